// File: rtl/coo_enc_hls_deadlock_report.sv
`timescale 1ns/1ps
// Debounces the coo_enc dataflow monitor's `block` flag into a sticky deadlock event,
// snapshots the AXIS/idle vectors with a timestamp, and offers them on a valid/ready channel.
module coo_enc_hls_deadlock_report #(
  parameter int unsigned THRESHOLD = 16,
  parameter int unsigned TS_W      = 32,
  parameter int unsigned EVT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             block,
  input  logic [3:0]       axis_block_sigs,
  input  logic [4:0]       inst_idle_sigs,
  input  logic             clear,
  input  logic             report_ready,
  output logic             report_valid,
  output logic [3:0]       report_axis,
  output logic [4:0]       report_idle,
  output logic [TS_W-1:0]  report_ts,
  output logic             deadlock_detected,
  output logic [EVT_W-1:0] event_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_REPORT,
    S_LATCHED
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(THRESHOLD - 1);

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             valid_q, valid_d;
  logic [3:0]       axis_q, axis_d;
  logic [4:0]       idle_q, idle_d;
  logic [TS_W-1:0]  rts_q, rts_d;
  logic             det_q, det_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ts_d    = ts_q + TS_W'(1);
    valid_d = valid_q;
    axis_d  = axis_q;
    idle_d  = idle_q;
    rts_d   = rts_q;
    det_d   = det_q;
    evt_d   = evt_q;

    // Acknowledge wins over a same-cycle detection or handshake; payload and count survive it.
    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      det_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (block) begin
            state_d = S_ARMED;
            cnt_d   = 16'd1;
          end
        end
        S_ARMED: begin
          if (!block) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_REPORT;
            cnt_d   = '0;
            axis_d  = axis_block_sigs;
            idle_d  = inst_idle_sigs;
            rts_d   = ts_q;
            valid_d = 1'b1;
            det_d   = 1'b1;
            if (evt_q != {EVT_W{1'b1}}) evt_d = evt_q + EVT_W'(1);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_REPORT: begin
          if (valid_q && report_ready) begin
            state_d = S_LATCHED;
            valid_d = 1'b0;
          end
        end
        S_LATCHED: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ts_q    <= '0;
      valid_q <= 1'b0;
      axis_q  <= '0;
      idle_q  <= '0;
      rts_q   <= '0;
      det_q   <= 1'b0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      valid_q <= valid_d;
      axis_q  <= axis_d;
      idle_q  <= idle_d;
      rts_q   <= rts_d;
      det_q   <= det_d;
      evt_q   <= evt_d;
    end
  end

  assign report_valid      = valid_q;
  assign report_axis       = axis_q;
  assign report_idle       = idle_q;
  assign report_ts         = rts_q;
  assign deadlock_detected = det_q;
  assign event_count       = evt_q;

endmodule

// File: tb/tb_coo_enc_hls_deadlock_report.sv
`timescale 1ns/1ps
// Bench for coo_enc_hls_deadlock_report: run-length reference model checked every cycle,
// plus directed scenarios with literal expectations; a TS_W=4 twin exercises timestamp wrap.
module tb_coo_enc_hls_deadlock_report;
  localparam int THR = 16;

  logic clock = 1'b0;
  logic reset = 1'b0, block = 1'b0, clear = 1'b0, report_ready = 1'b0;
  logic [3:0] axis = '0;
  logic [4:0] idle = '0;

  logic        rv, det, s_rv, s_det;
  logic [3:0]  ra, s_ra, s_rts;
  logic [4:0]  ri, s_ri;
  logic [31:0] rts;
  logic [7:0]  evt, s_evt;

  coo_enc_hls_deadlock_report #(.THRESHOLD(THR), .TS_W(32), .EVT_W(8)) dut (
    .clock(clock), .reset(reset), .block(block), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .clear(clear), .report_ready(report_ready),
    .report_valid(rv), .report_axis(ra), .report_idle(ri), .report_ts(rts),
    .deadlock_detected(det), .event_count(evt));

  coo_enc_hls_deadlock_report #(.THRESHOLD(THR), .TS_W(4), .EVT_W(8)) dut_ts4 (
    .clock(clock), .reset(reset), .block(block), .axis_block_sigs(axis),
    .inst_idle_sigs(idle), .clear(clear), .report_ready(report_ready),
    .report_valid(s_rv), .report_axis(s_ra), .report_idle(s_ri), .report_ts(s_rts),
    .deadlock_detected(s_det), .event_count(s_evt));

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: length of the current high run, an outstanding-report flag and a sticky flag.
  int          m_run = 0;
  int          m_evt = 0;
  bit          m_pend = 1'b0, m_det = 1'b0;
  logic [3:0]  m_axis = '0;
  logic [4:0]  m_idle = '0;
  logic [31:0] m_ts = '0, m_rts = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_run = 0; m_evt = 0; m_pend = 1'b0; m_det = 1'b0;
      m_axis = '0; m_idle = '0; m_ts = '0; m_rts = '0;
    end else begin
      if (clear) begin
        m_pend = 1'b0; m_det = 1'b0; m_run = 0;
      end else if (m_det) begin
        if (m_pend && report_ready) m_pend = 1'b0;
      end else if (block) begin
        m_run++;
        if (m_run == THR) begin
          m_axis = axis; m_idle = idle; m_rts = m_ts;
          m_pend = 1'b1; m_det = 1'b1; m_run = 0;
          if (m_evt < 255) m_evt++;
        end
      end else begin
        m_run = 0;
      end
      m_ts = m_ts + 32'd1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("valid", rv, m_pend);
      check("detected", det, m_det);
      check("axis", ra, m_axis);
      check("idle", ri, m_idle);
      check("ts", rts, m_rts);
      check("evt", evt, m_evt);
      check("ts4_valid", s_rv, m_pend);
      check("ts4_ts", s_rts, m_rts[3:0]);
      check("ts4_evt", s_evt, m_evt);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!rv && n < max) begin
      step();
      n++;
    end
    if (!rv) check("wait_valid_timeout", rv, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    check("rst_valid", rv, 0);
    check("rst_det", det, 0);
    check("rst_evt", evt, 0);
    check("rst_ts", rts, 0);
    check("rst_axis", ra, 0);

    // Basic detection: block high from timestamp 10, snapshot taken on timestamp 25.
    while (m_ts != 32'd10) step();
    block = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        axis = 4'b0101; idle = 5'b10011;
        check("basic_pre_valid", rv, 0);
      end else begin
        axis = 4'($urandom); idle = 5'($urandom);
      end
      step();
    end
    check("basic_valid", rv, 1);
    check("basic_axis", ra, 4'b0101);
    check("basic_idle", ri, 5'b10011);
    check("basic_ts", rts, 25);
    check("basic_det", det, 1);
    check("basic_evt", evt, 1);

    // Backpressure: payload holds while ready stays low.
    for (int i = 0; i < 5; i++) begin
      axis = 4'($urandom); idle = 5'($urandom);
      step();
      check("bp_valid", rv, 1);
      check("bp_axis", ra, 4'b0101);
      check("bp_idle", ri, 5'b10011);
      check("bp_ts", rts, 25);
    end
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    check("hs_valid", rv, 0);
    check("hs_det", det, 1);
    check("hs_axis", ra, 4'b0101);

    // Broken run: 15 high, 1 low, then a full run of 16.
    block = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_det", det, 0);
    block = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check("brk_valid", rv, 0);
    end
    block = 1'b0;
    step();
    check("brk_gap_valid", rv, 0);
    block = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check("rerun_valid", rv, (i == 16));
    end
    check("rerun_evt", evt, 2);

    // Clear collides with a handshake: report dropped, fresh run required.
    clear = 1'b1; report_ready = 1'b1;
    step();
    clear = 1'b0; report_ready = 1'b0;
    check("col_valid", rv, 0);
    check("col_det", det, 0);
    wait_valid(40, n);
    check("col_latency", n, 16);
    check("col_evt", evt, 3);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      block        = ($urandom_range(0, 99) < 92);
      report_ready = ($urandom_range(0, 99) < 30);
      clear        = ($urandom_range(0, 99) < 2);
      reset        = ($urandom_range(0, 199) == 0);
      axis         = 4'($urandom);
      idle         = 5'($urandom);
      step();
    end
    reset = 1'b0; clear = 1'b0; report_ready = 1'b0;

    // Timestamp wrap on the 4-bit twin: detection on timestamp 17 reports 1.
    block = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    while (m_ts != 32'd2) step();
    block = 1'b1;
    for (int i = 0; i < 16; i++) step();
    check("wrap_valid", rv, 1);
    check("wrap_ts32", rts, 17);
    check("wrap_ts4", s_rts, 1);

    // Reset while a report is pending.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", rv, 0);
    check("mid_rst_det", det, 0);
    check("mid_rst_evt", evt, 0);
    check("mid_rst_ts", rts, 0);
    check("mid_rst_axis", ra, 0);
    check("mid_rst_idle", ri, 0);
    for (int i = 0; i < 16; i++) step();
    check("restart_valid", rv, 1);
    check("restart_ts", rts, 15);

    // Saturation: 260 detect/handshake/clear rounds.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 260; k++) begin
      wait_valid(40, n);
      report_ready = 1'b1;
      step();
      report_ready = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
    end
    check("sat_evt", evt, 255);
    check("sat_evt_ts4", s_evt, 255);

    block = 1'b0;
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/coo_enc_hls_deadlock_report.md
Name: coo_enc_hls_deadlock_report

Overview:
- Downstream consumer of the top-level dataflow deadlock monitor's `block` output for the coo_enc instance.
- Turns the per-cycle `block` indication into a debounced, sticky deadlock event.
- On each event, captures a snapshot of the AXIS block and instance idle vectors plus a timestamp.
- Presents the snapshot on a valid/ready report channel for a debug/trace sink.

Parameters:
- THRESHOLD, 16: consecutive cycles `block` must be high before a deadlock is declared; legal range 2..65535.
- TS_W, 32: width of the free-running timestamp counter.
- EVT_W, 8: width of the saturating deadlock event counter.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- block  in  1  deadlock-suspect flag from the dataflow monitor (registered upstream).
- axis_block_sigs  in  4  per-AXIS-channel blocked flags; same vector the monitor sees.
- inst_idle_sigs  in  5  per-process idle flags.
- clear  in  1  software acknowledge; re-arms the detector.
- report_ready  in  1  sink ready.
- report_valid  out  1  snapshot available.
- report_axis  out  4  captured axis_block_sigs.
- report_idle  out  5  captured inst_idle_sigs.
- report_ts  out  TS_W  timestamp at detection.
- deadlock_detected  out  1  sticky deadlock flag.
- event_count  out  EVT_W  number of deadlocks declared since reset, saturating.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, the debounce counter is 0, and the timestamp is 0. Reset overrides every other input.
- Timestamp: increments by 1 every cycle and wraps from all-ones to 0. The first cycle after reset is timestamp 0.
- The FSM has four states: IDLE, ARMED, REPORT, LATCHED. The debounce counter is 16 bits.
- IDLE:
  - block=1 → ARMED with cnt←1.
  - Otherwise stay in IDLE.
- ARMED:
  - block=0 → IDLE with cnt←0 (the run is broken and the count does not accumulate).
  - block=1 with cnt==THRESHOLD-1 → REPORT. On that edge:
    - capture report_axis←axis_block_sigs, report_idle←inst_idle_sigs, and report_ts←the current timestamp (the THRESHOLD-th high cycle);
    - set report_valid←1 and deadlock_detected←1;
    - increment event_count unless it is all-ones.
  - Otherwise cnt←cnt+1.
- Detection latency: report_valid first rises one cycle after the THRESHOLD-th consecutive high cycle of `block`.
- REPORT:
  - report_valid stays high and the payload is held stable until a cycle with report_valid & report_ready.
  - On that handshake → LATCHED, with report_valid←0 on the following edge.
  - `block` is ignored in this state.
- LATCHED:
  - deadlock_detected holds at 1 and `block` is ignored.
  - clear=1 → IDLE.
- clear:
  - clear=1 in any state forces IDLE, cnt←0, report_valid←0, deadlock_detected←0.
  - The payload registers and event_count keep their values.
  - clear has priority over a same-cycle detection or handshake. If clear and report_ready are both high in REPORT, the report is dropped and the state goes to IDLE.
  - After clear, a new deadlock needs a full fresh run of THRESHOLD consecutive high cycles; the clear cycle itself does not count.
- Saturation: once event_count reaches all-ones, it holds that value until reset.
- Payload registers change only on entry to REPORT and hold otherwise, including across clear.
- Mid-operation reset in any state returns to the reset values on the next edge. A pending report is lost.

Test Plan (THRESHOLD=16, TS_W=32, EVT_W=8):
- Basic detection:
  - Stimulus: after reset, hold block=1 from timestamp 10, with axis=4'b0101 and idle=5'b10011 on cycle 25.
  - Required: report_valid=1 from timestamp 26, report_axis=0101, report_idle=10011, report_ts=25, deadlock_detected=1, event_count=1.
- Broken run:
  - Stimulus: block=1 for 15 cycles, 0 for 1 cycle, then 1 for 16 cycles.
  - Required: no report_valid during the first run; report_valid rises exactly 16 cycles after the second run starts.
- Backpressure:
  - Stimulus: report_ready=0 for 5 cycles after report_valid rises, while axis and idle keep changing.
  - Required: payload and report_valid stay constant; valid drops the edge after the ready=1 cycle; deadlock_detected stays 1.
- Clear versus handshake collision:
  - Stimulus: in REPORT, drive clear=1 and report_ready=1 on the same cycle.
  - Required: next cycle report_valid=0, deadlock_detected=0, state IDLE. With block held at 1, a re-report occurs 16 cycles after clear deasserts, and event_count=2.
- Saturation and wrap:
  - Stimulus: force 260 detect/handshake/clear cycles.
  - Required: event_count stays at 255. With TS_W=4, report_ts wraps (a detection on cycle 17 reports 1).
- Reset mid-REPORT:
  - Stimulus: assert reset for 1 cycle while report_valid=1.
  - Required: all outputs are 0 on the next cycle and the timestamp restarts at 0.
